// File: rtl/sample_read_master.sv
// sample_read_master: serves 32-bit samples to a game controller from a small
// word buffer. Misses are filled with single Avalon-MM reads, one outstanding at most.
// Latency: a hit is combinational. A miss that finds the FSM idle completes 2 + L cycles
//   after it is first seen, where L is the slave read latency after acceptance.
// Backpressure: avm_waitrequest holds avm_read and avm_address stable until accepted.
//   tl_read is a level request with no handshake, and tl_rdv is a level qualifier.
// Optional feature: define SAMPLE_READ_PREFETCH_EN to add entry E1 and sequential
// next-word prefetch. The default build has the single entry E0 and issues demand reads only.
//
// Ports
//   Clk, Reset            : clock, synchronous active-high reset
//   tl_read, tl_addr      : level read request and byte address (bits [1:0] ignored)
//   tl_rdv, sample        : hit flag and hit data (sample is 0 when tl_rdv is 0)
//   avm_*                 : Avalon-MM read master (byteenable fixed at 4'hF)
module sample_read_master (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        tl_read,
  input  logic [31:0] tl_addr,
  output logic        tl_rdv,
  output logic [31:0] sample,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic [3:0]  avm_byteenable,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [29:0] req_addr_q, req_addr_d;

  logic        e0_vld_q, e0_vld_d;
  logic [29:0] e0_addr_q, e0_addr_d;
  logic [31:0] e0_data_q, e0_data_d;

  logic [29:0] tl_word;
  logic        hit0;
  logic        hit;
  logic        unused_tl_lsb;

  assign tl_word       = tl_addr[31:2];
  assign unused_tl_lsb = ^tl_addr[1:0];
  assign hit0          = tl_read & e0_vld_q & (e0_addr_q == tl_word);

`ifdef SAMPLE_READ_PREFETCH_EN
  logic        e1_vld_q, e1_vld_d;
  logic [29:0] e1_addr_q, e1_addr_d;
  logic [31:0] e1_data_q, e1_data_d;
  logic        hit1;
  // tgt: entry the outstanding read fills. victim: entry not most recently hit.
  logic        tgt_q, tgt_d;
  logic        victim_q, victim_d;
  logic        pf_go;
  logic [29:0] pf_addr;
  logic        pf_tgt;

  assign hit1   = tl_read & e1_vld_q & (e1_addr_q == tl_word);
  assign hit    = hit0 | hit1;
  assign sample = hit0 ? e0_data_q : (hit1 ? e1_data_q : 32'd0);

  // Prefetch the word after the hit entry into the other entry unless it is already there.
  // The 30-bit word increment wraps, so byte address 32'hFFFF_FFFC is followed by 0.
  always_comb begin
    pf_go   = 1'b0;
    pf_addr = '0;
    pf_tgt  = 1'b0;
    if (hit0) begin
      pf_addr = e0_addr_q + 30'd1;
      pf_tgt  = 1'b1;
      pf_go   = !(e1_vld_q && (e1_addr_q == pf_addr));
    end else if (hit1) begin
      pf_addr = e1_addr_q + 30'd1;
      pf_tgt  = 1'b0;
      pf_go   = !(e0_vld_q && (e0_addr_q == pf_addr));
    end
  end
`else
  assign hit    = hit0;
  assign sample = hit0 ? e0_data_q : 32'd0;
`endif

  assign tl_rdv         = hit;
  assign avm_read       = (state_q == ST_REQ);
  assign avm_address    = {req_addr_q, 2'b00};
  assign avm_byteenable = 4'hF;

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    e0_vld_d   = e0_vld_q;
    e0_addr_d  = e0_addr_q;
    e0_data_d  = e0_data_q;
`ifdef SAMPLE_READ_PREFETCH_EN
    e1_vld_d   = e1_vld_q;
    e1_addr_d  = e1_addr_q;
    e1_data_d  = e1_data_q;
    tgt_d      = tgt_q;
    victim_d   = victim_q;
    if (hit0) begin
      victim_d = 1'b1;
    end else if (hit1) begin
      victim_d = 1'b0;
    end
`endif
    case (state_q)
      ST_IDLE: begin
        // Demand misses take priority. A prefetch needs a hit, so it never competes with one.
        if (tl_read && !hit) begin
          req_addr_d = tl_word;
`ifdef SAMPLE_READ_PREFETCH_EN
          tgt_d      = victim_q;
`endif
          state_d    = ST_REQ;
        end
`ifdef SAMPLE_READ_PREFETCH_EN
        else if (pf_go) begin
          req_addr_d = pf_addr;
          tgt_d      = pf_tgt;
          state_d    = ST_REQ;
        end
`endif
      end
      ST_REQ: begin
        if (!avm_waitrequest) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // The fill always completes, even if tl_addr moved away or tl_read dropped.
        // IDLE then re-evaluates the request against whatever tl_addr is current.
        if (avm_readdatavalid) begin
`ifdef SAMPLE_READ_PREFETCH_EN
          if (tgt_q) begin
            e1_vld_d  = 1'b1;
            e1_addr_d = req_addr_q;
            e1_data_d = avm_readdata;
          end else begin
            e0_vld_d  = 1'b1;
            e0_addr_d = req_addr_q;
            e0_data_d = avm_readdata;
          end
`else
          e0_vld_d  = 1'b1;
          e0_addr_d = req_addr_q;
          e0_data_d = avm_readdata;
`endif
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Responses that arrive in IDLE or REQ, such as those left over from a read cut off by
  // reset, are ignored because only WAIT consumes them.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      req_addr_q <= '0;
      e0_vld_q   <= 1'b0;
      e0_addr_q  <= '0;
      e0_data_q  <= '0;
`ifdef SAMPLE_READ_PREFETCH_EN
      e1_vld_q   <= 1'b0;
      e1_addr_q  <= '0;
      e1_data_q  <= '0;
      tgt_q      <= 1'b0;
      victim_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      e0_vld_q   <= e0_vld_d;
      e0_addr_q  <= e0_addr_d;
      e0_data_q  <= e0_data_d;
`ifdef SAMPLE_READ_PREFETCH_EN
      e1_vld_q   <= e1_vld_d;
      e1_addr_q  <= e1_addr_d;
      e1_data_q  <= e1_data_d;
      tgt_q      <= tgt_d;
      victim_q   <= victim_d;
`endif
    end
  end

endmodule

// File: tb/tb_sample_read_master.sv
// Bench for sample_read_master. It uses an Avalon slave model with programmable stall
// and latency, a table of single-miss timing vectors, hand sequences for abandoned
// fetches, reset and prefetch, and a random phase checked against a reference model.
module tb_sample_read_master;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        tl_read;
  logic [31:0] tl_addr;
  logic        tl_rdv;
  logic [31:0] sample;
  logic [31:0] avm_address;
  logic        avm_read;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;

  sample_read_master dut (
    .Clk              (Clk),
    .Reset            (Reset),
    .tl_read          (tl_read),
    .tl_addr          (tl_addr),
    .tl_rdv           (tl_rdv),
    .sample           (sample),
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_byteenable   (avm_byteenable),
    .avm_waitrequest  (avm_waitrequest),
    .avm_readdata     (avm_readdata),
    .avm_readdatavalid(avm_readdatavalid)
  );

  always #5 Clk = ~Clk;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory contents seen through the slave. Word 0 reads as 32'h0000_1234.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return (w * 32'h9E37_79B1) ^ 32'h0000_1234;
  endfunction

  // ---------------- Avalon slave model ----------------
  typedef struct { int due; logic [31:0] addr; } rsp_t;
  rsp_t        rspq[$];
  rsp_t        slv_r;
  logic [31:0] acc_addr_q[$];
  int          cyc = 0, acc_cnt = 0, rsp_cnt = 0;
  int          stall_cfg = 0, lat_cfg = 2, stall_left = 0, slv_lat;
  bit          rand_slave = 0, new_req = 1;
  logic [31:0] slv_rsp_addr = '0;

  // All slave decisions happen on the falling edge, for the cycle in progress.
  initial begin
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = 32'hDEAD_BEEF;
    forever begin
      @(negedge Clk);
      cyc++;
      avm_readdatavalid = 1'b0;
      avm_readdata      = 32'hDEAD_BEEF;
      if (rspq.size() > 0 && rspq[0].due <= cyc) begin
        slv_r             = rspq.pop_front();
        avm_readdatavalid = 1'b1;
        avm_readdata      = mem_word(slv_r.addr);
        slv_rsp_addr      = slv_r.addr;
        rsp_cnt++;
      end
      if (avm_read) begin
        if (new_req) begin
          stall_left = rand_slave ? $urandom_range(0, 2) : stall_cfg;
          new_req    = 0;
        end
        avm_waitrequest = (stall_left > 0);
        if (stall_left > 0) begin
          stall_left--;
        end else begin
          slv_lat = rand_slave ? $urandom_range(1, 4) : lat_cfg;
          rspq.push_back('{cyc + slv_lat, avm_address});
          acc_addr_q.push_back(avm_address);
          acc_cnt++;
          new_req = 1;
        end
      end else begin
        avm_waitrequest = 1'b0;
        new_req         = 1;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic sample_pt();
    @(negedge Clk); #2;
  endtask

  // Reset is held for 6 cycles, longer than the slave's longest latency.
  task automatic do_reset();
    tick();
    Reset = 1'b1; tl_read = 1'b0; tl_addr = '0;
    repeat (6) tick();
    Reset = 1'b0;
    sample_pt();
    chk("reset_avm_read", avm_read, 1'b0);
    chk("reset_tl_rdv", tl_rdv, 1'b0);
    chk("reset_sample", sample, 32'd0);
    chk("reset_avm_address", avm_address, 32'd0);
    chk("reset_byteenable", avm_byteenable, 4'hF);
  endtask

  task automatic wait_rdv(output int got);
    got = -1;
    for (int k = 0; k < 40; k++) begin
      sample_pt();
      if (tl_rdv) begin
        got = k;
        break;
      end
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    int          stall;
    int          lat;
    int          exp_cyc;   // cycle of first tl_rdv, with cycle 0 being the miss
    int          exp_rdc;   // cycles with avm_read asserted
    logic [31:0] exp_data;
  } vec_t;
  vec_t vecs[5];

  logic [31:0] pool[8];
  int          got, rdc, a0, hold;
  bit          seen, early;
  logic [31:0] first_addr, sdat;
  bit          model_vld;
  logic [29:0] model_word;
  localparam int LIVE = 24;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    Reset = 1'b1; tl_read = 1'b0; tl_addr = '0;

    vecs[0] = '{32'h0000_0000, 0, 2, 4, 1, 32'h0000_1234};
    vecs[1] = '{32'h0000_0010, 3, 1, 6, 4, mem_word(32'h10)};
    vecs[2] = '{32'h8000_0007, 0, 1, 3, 1, mem_word(32'h8000_0004)};
    vecs[3] = '{32'hFFFF_FFFC, 1, 4, 7, 2, mem_word(32'hFFFF_FFFC)};
    vecs[4] = '{32'h0000_0040, 2, 3, 7, 3, mem_word(32'h40)};

    // ---- single-miss timing vectors ----
    for (int i = 0; i < 5; i++) begin
      rand_slave = 0; stall_cfg = vecs[i].stall; lat_cfg = vecs[i].lat;
      do_reset();
      tick();
      tl_addr = vecs[i].addr; tl_read = 1'b1; a0 = acc_cnt;
      got = -1; rdc = 0; first_addr = 32'hX;
      for (int k = 0; k < 40 && got < 0; k++) begin
        sample_pt();
        if (avm_read) begin
          rdc++;
          if (rdc == 1) first_addr = avm_address;
        end
        if (tl_rdv) begin
          got  = k;
          sdat = sample;
        end
      end
      chk($sformatf("vec%0d_rdv_cycle", i), got, vecs[i].exp_cyc);
      chk($sformatf("vec%0d_read_cycles", i), rdc, vecs[i].exp_rdc);
      chk($sformatf("vec%0d_accepted", i), acc_cnt - a0, 1);
      chk($sformatf("vec%0d_avm_address", i), first_addr, {vecs[i].addr[31:2], 2'b00});
      chk($sformatf("vec%0d_sample", i), sdat, vecs[i].exp_data);
      seen = 1;
      repeat (3) begin
        sample_pt();
        if (!tl_rdv) seen = 0;
      end
      chk($sformatf("vec%0d_rdv_held", i), seen, 1'b1);
    end

    // ---- address changes while WAIT_DATA: the first fill lands unseen, then 0x20 is fetched ----
    rand_slave = 0; stall_cfg = 0; lat_cfg = 3;
    do_reset();
    tick();
    tl_addr = 32'h10; tl_read = 1'b1; a0 = acc_cnt;
    for (int k = 0; k < 20 && acc_cnt == a0; k++) sample_pt();
    chk("abandon_first_accepted", acc_cnt - a0, 1);
    tick();
    tl_addr = 32'h20;
    early = 0; got = -1;
    for (int k = 0; k < 40 && got < 0; k++) begin
      sample_pt();
      if (tl_rdv && (acc_cnt - a0) < 2) early = 1;
      if (tl_rdv) begin
        got  = k;
        sdat = sample;
      end
    end
    chk("abandon_no_early_rdv", early, 1'b0);
    chk("abandon_rdv_seen", (got >= 0), 1'b1);
    chk("abandon_two_reads", acc_cnt - a0, 2);
    chk("abandon_second_addr", (acc_addr_q.size() > a0 + 1) ? acc_addr_q[a0 + 1] : 32'hX, 32'h20);
    chk("abandon_sample", sdat, mem_word(32'h20));

    // ---- reset while in REQ: the cached word must be refetched afterwards ----
    stall_cfg = 0; lat_cfg = 2;
    do_reset();
    tick();
    tl_addr = 32'h30; tl_read = 1'b1;
    wait_rdv(got);
    chk("rstreq_first_fill", got, 4);
    repeat (8) sample_pt();
    stall_cfg = 5;
    tick();
    tl_addr = 32'h80;
    seen = 0;
    for (int k = 0; k < 12 && !seen; k++) begin
      sample_pt();
      if (avm_read && avm_address == 32'h80) seen = 1;
    end
    chk("rstreq_in_req", seen, 1'b1);
    tick();
    Reset = 1'b1;
    sample_pt();
    sample_pt();
    chk("rstreq_avm_read", avm_read, 1'b0);
    chk("rstreq_tl_rdv", tl_rdv, 1'b0);
    chk("rstreq_avm_address", avm_address, 32'd0);
    stall_cfg = 0; tl_addr = 32'h30; tl_read = 1'b1;
    repeat (5) tick();
    Reset = 1'b0; a0 = acc_cnt;
    sample_pt();
    chk("rstreq_cached_now_miss", tl_rdv, 1'b0);
    wait_rdv(got);
    chk("rstreq_refetch_cycle", got, 3);
    chk("rstreq_refetch_reads", acc_cnt - a0, 1);
    chk("rstreq_refetch_sample", sample, mem_word(32'h30));

`ifdef SAMPLE_READ_PREFETCH_EN
    // ---- sequential prefetch of 0 -> 4 -> 8 ----
    stall_cfg = 0; lat_cfg = 2;
    do_reset();
    tick();
    tl_addr = 32'h0; tl_read = 1'b1; a0 = acc_cnt;
    repeat (10) sample_pt();
    tick();
    tl_addr = 32'h4;
    sample_pt();
    chk("pf_hit4_rdv", tl_rdv, 1'b1);
    chk("pf_hit4_sample", sample, mem_word(32'h4));
    repeat (8) sample_pt();
    tick();
    tl_addr = 32'h8;
    sample_pt();
    chk("pf_hit8_rdv", tl_rdv, 1'b1);
    chk("pf_hit8_sample", sample, mem_word(32'h8));
    chk("pf_addr1", (acc_addr_q.size() > a0 + 2) ? acc_addr_q[a0 + 1] : 32'hX, 32'h4);
    chk("pf_addr2", (acc_addr_q.size() > a0 + 2) ? acc_addr_q[a0 + 2] : 32'hX, 32'h8);

    // ---- prefetch past the top of the address space wraps to 0 ----
    do_reset();
    tick();
    tl_addr = 32'hFFFF_FFFC; tl_read = 1'b1; a0 = acc_cnt;
    repeat (12) sample_pt();
    chk("pf_wrap_addr", (acc_addr_q.size() > a0 + 1) ? acc_addr_q[a0 + 1] : 32'hX, 32'h0);
`endif

    // ---- random phase ----
    pool[0] = 32'h100; pool[1] = 32'h104; pool[2] = 32'h108; pool[3] = 32'h10C;
    pool[4] = 32'h200; pool[5] = 32'hFFFF_FFFC; pool[6] = 32'h0; pool[7] = 32'h204;
    rand_slave = 1;
    do_reset();
    model_vld = 0; model_word = '0;
    for (int r = 0; r < 250; r++) begin
      tick();
      if ($urandom_range(0, 15) == 0) tl_addr = $urandom;
      else tl_addr = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
      tl_read = ($urandom_range(0, 7) != 0);
      hold = $urandom_range(1, 32);
      for (int k = 0; k < hold; k++) begin
        sample_pt();
        if (tl_rdv) chk("rand_sample", sample, mem_word(tl_addr));
        else chk("rand_sample_zero", sample, 32'd0);
        chk("rand_rdv_without_read", tl_rdv & ~tl_read, 1'b0);
        chk("rand_one_outstanding", (acc_cnt - rsp_cnt) <= 1, 1'b1);
        chk("rand_addr_aligned", avm_address[1:0], 2'b00);
`ifndef SAMPLE_READ_PREFETCH_EN
        // Single entry: it holds the most recently returned word.
        chk("rand_hit_model", tl_rdv, tl_read && model_vld && (model_word == tl_addr[31:2]));
        if (avm_readdatavalid) begin
          model_vld  = 1;
          model_word = slv_rsp_addr[31:2];
        end
`endif
        if (tl_read && k == LIVE) chk("rand_liveness", tl_rdv, 1'b1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/sample_read_master.md
SAMPLE_READ_MASTER -- requirements
Module: sample_read_master

Interface
REQ-001 Clk  input  1  system clock; all state changes on posedge Clk.
REQ-002 Reset  input  1  synchronous, active-high reset.
REQ-003 tl_read  input  1  read request from game controller; level, held while address valid.
REQ-004 tl_addr  input  32  byte address of requested sample; bits [1:0] ignored.
REQ-005 tl_rdv  output  1  sample valid for current tl_addr (level).
REQ-006 sample  output  32  sample data for current tl_addr; 32'd0 when tl_rdv=0.
REQ-007 avm_address  output  32  Avalon-MM read address, always {addr[31:2],2'b00}.
REQ-008 avm_read  output  1  Avalon-MM read strobe.
REQ-009 avm_byteenable  output  4  constant 4'hF.
REQ-010 avm_waitrequest  input  1  slave stall; command accepted when avm_read=1 and avm_waitrequest=0.
REQ-011 avm_readdata  input  32  read response data.
REQ-012 avm_readdatavalid  input  1  response strobe; one per accepted read, in order.

Function
REQ-013 Block SHALL hold buffer entries E0 (and E1 when PREFETCH_EN) of {valid, addr[31:2], data[31:0]}.
REQ-014 Hit SHALL mean tl_read=1 and some valid Ek with Ek.addr == tl_addr[31:2]; tl_rdv=hit and sample=Ek.data, combinational from registered entries.
REQ-015 FSM states SHALL be IDLE, REQ, WAIT_DATA; at most one Avalon read outstanding.
REQ-016 IDLE: on tl_read=1 and miss, latch tl_addr[31:2] into req_addr, mark request demand, go REQ next cycle; otherwise remain IDLE.
REQ-017 REQ: avm_read=1, avm_address=req_addr; hold until avm_waitrequest=0, then WAIT_DATA next cycle.
REQ-018 WAIT_DATA: avm_read=0; on avm_readdatavalid=1 write {1,req_addr,avm_readdata} into target entry, return to IDLE next cycle; tl_rdv rises the cycle after avm_readdatavalid when address still matches.
REQ-019 Demand fill target SHALL be victim entry (entry not most recently hit); without PREFETCH_EN always E0.
REQ-020 tl_addr change or tl_read drop mid-fetch SHALL NOT cancel the fetch; the fill completes and IDLE re-evaluates hit/miss against the then-current tl_addr.
REQ-021 avm_readdatavalid outside WAIT_DATA SHALL be ignored.
REQ-022 Latency: miss seen in IDLE at cycle 0, waitrequest=0, read latency L cycles after acceptance -> tl_rdv high at cycle 2+L.
REQ-023 Address arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 32'h0000_0000.

Reset
REQ-024 On Reset=1 at a posedge: state IDLE, all valid bits 0, victim=E0, avm_read=0, avm_address=0, tl_rdv=0, sample=0, regardless of current state or outstanding read.
REQ-025 System SHALL hold Reset at least as long as the slave's maximum read latency; any response arriving after is discarded per REQ-021.

Configuration
REQ-026 Macro SAMPLE_READ_PREFETCH_EN defined: E1 exists; in IDLE with no demand miss, when entry Ek is hit and the other entry does not hold Ek.addr+1 (word), SHALL launch prefetch of (Ek.addr+1) into the other entry via REQ/WAIT_DATA.
REQ-027 With macro: demand miss arising during a prefetch SHALL wait for the prefetch to complete, then be issued next from IDLE; demand has priority over prefetch in IDLE.
REQ-028 Macro undefined: single entry E0, no speculative reads; avm_read asserted only for demand misses.

Verification
REQ-029 Reset, tl_read=1, tl_addr=0, waitrequest=0, latency 2, readdata=32'h0000_1234 -> avm_read one cycle at addr 0, tl_rdv=1 with sample=32'h1234 at cycle 4, held while addr stable.
REQ-030 waitrequest held 3 cycles on miss to 0x10 -> avm_read/avm_address stable for 4 cycles, exactly one read accepted.
REQ-031 tl_addr 0x10 -> 0x20 while WAIT_DATA -> 0x10 fill completes, tl_rdv stays 0, second read to 0x20 issued from IDLE, tl_rdv=1 after its response.
REQ-032 PREFETCH_EN, sequential addrs 0,4,8 with latency 2 -> reads to 4 and 8 issued speculatively; tl_rdv=1 in the same cycle tl_addr steps to 4 and to 8.
REQ-033 Reset asserted in REQ -> next cycle avm_read=0, tl_rdv=0, previously cached addr misses and refetches.
REQ-034 tl_addr=32'hFFFF_FFFC with PREFETCH_EN -> prefetch avm_address=32'h0000_0000.
